// File: rtl/wcs_pkg.sv
// wcs_pkg: shared types and constants for the writable-control-store loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: loader state enum, default address/data widths, bytes per
//           microword, and the word count that a COUNT byte of zero stands for.
package wcs_pkg;

  localparam int WCS_ADDR_W       = 8;
  localparam int WCS_DATA_W       = 22;
  localparam int BYTES_PER_WORD   = 3;
  localparam int COUNT_ZERO_WORDS = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CNT,
    ST_ADR,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WR,
    ST_CHK,
    ST_FIN
  } wcs_state_e;

endpackage

// File: rtl/wcs_word_asm.sv
// wcs_word_asm: assembles stream bytes into a microword, checks pad bits, keeps running XOR.
// Latency: word_nxt/pad_bad are combinational on the top byte; lower bytes are registered.
// Backpressure: none of its own; it only observes transfers already qualified by the FSM.
// Ports: clock, reset, clear (new load accepted), xfer (byte accepted), state,
//        byte_dat -> word_nxt (assembled word), pad_bad (top-byte pad bits set),
//        chk_acc (XOR of all accepted bytes; only when WCS_CHECKSUM_EN is defined).
// Build option: WCS_CHECKSUM_EN adds the checksum accumulator output.
module wcs_word_asm
  import wcs_pkg::*;
#(
  parameter int DATA_W = WCS_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              xfer,
  input  wcs_state_e        state,
  input  logic [7:0]        byte_dat,
  output logic [DATA_W-1:0] word_nxt,
  output logic              pad_bad
`ifdef WCS_CHECKSUM_EN
 ,output logic [7:0]        chk_acc
`endif
);

  // Number of microword bits carried by the last byte of a word.
  localparam int         HI_BITS  = DATA_W - 8 * (BYTES_PER_WORD - 1);
  localparam logic [7:0] PAD_MASK = 8'hFF << HI_BITS;

  logic [7:0] b0_q;
  logic [7:0] b1_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      b0_q <= 8'd0;
      b1_q <= 8'd0;
    end else if (xfer) begin
      if (state == ST_B0) b0_q <= byte_dat;
      if (state == ST_B1) b1_q <= byte_dat;
    end
  end

  // Valid only while the top byte is on the bus; the FSM samples it then.
  assign word_nxt = {byte_dat[HI_BITS-1:0], b1_q, b0_q};
  assign pad_bad  = |(byte_dat & PAD_MASK);

`ifdef WCS_CHECKSUM_EN
  // The CHK byte is folded in too; harmless, the comparison happens before it lands.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      chk_acc <= 8'd0;
    end else if (xfer) begin
      chk_acc <= chk_acc ^ byte_dat;
    end
  end
`endif

endmodule

// File: rtl/wcs_loader.sv
// wcs_loader: byte-stream loader that writes 22-bit microwords into the control store.
// Latency: wcs_we one cycle after the last byte of a word; N words take >= 2+4N(+1 CHK)+1 cycles.
// Backpressure: load_ready drops during WR/FIN/IDLE; stalls indefinitely while load_valid is low.
// Ports: clock, reset (sync, active-high), start, load_data/load_valid/load_ready (byte
//        stream in), wcs_we/wcs_addr/wcs_wdata (control-store write port), cpu_hold,
//        done (one-cycle success pulse), error (sticky until next accepted start).
// Build option: WCS_CHECKSUM_EN expects a trailing XOR checksum byte after the last word.
module wcs_loader
  import wcs_pkg::*;
#(
  parameter int ADDR_W = WCS_ADDR_W,
  parameter int DATA_W = WCS_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              wcs_we,
  output logic [ADDR_W-1:0] wcs_addr,
  output logic [DATA_W-1:0] wcs_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(COUNT_ZERO_WORDS + 1);

  wcs_state_e        state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remain;
  logic              xfer;
  logic              load_start;
  logic [DATA_W-1:0] word_nxt;
  logic              pad_bad;
`ifdef WCS_CHECKSUM_EN
  logic [7:0]        chk_acc;
`endif

  assign xfer       = load_valid & load_ready;
  assign load_start = (state == ST_IDLE) & start;

  wcs_word_asm #(.DATA_W(DATA_W)) u_asm (
    .clock    (clock),
    .reset    (reset),
    .clear    (load_start),
    .xfer     (xfer),
    .state    (state),
    .byte_dat (load_data),
    .word_nxt (word_nxt),
    .pad_bad  (pad_bad)
`ifdef WCS_CHECKSUM_EN
   ,.chk_acc  (chk_acc)
`endif
  );

  // All outputs are registered; load_ready is set on the edge entering a byte state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remain     <= '0;
      load_ready <= 1'b0;
      wcs_we     <= 1'b0;
      wcs_addr   <= '0;
      wcs_wdata  <= '0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wcs_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_CNT;
            load_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            error      <= 1'b0;
          end
        end
        ST_CNT: begin
          if (xfer) begin
            remain <= (load_data == 8'd0) ? CNT_W'(COUNT_ZERO_WORDS) : CNT_W'(load_data);
            state  <= ST_ADR;
          end
        end
        ST_ADR: begin
          if (xfer) begin
            addr  <= ADDR_W'(load_data);
            state <= ST_B0;
          end
        end
        ST_B0: if (xfer) state <= ST_B1;
        ST_B1: if (xfer) state <= ST_B2;
        ST_B2: begin
          if (xfer) begin
            load_ready <= 1'b0;
            if (pad_bad) begin
              // Offending word is dropped; earlier words stay in the store.
              error    <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              wcs_we    <= 1'b1;
              wcs_addr  <= addr;
              wcs_wdata <= word_nxt;
              state     <= ST_WR;
            end
          end
        end
        ST_WR: begin
          addr   <= addr + ADDR_W'(1);   // wraps at the top of the store by design
          remain <= remain - CNT_W'(1);
          if (remain != CNT_W'(1)) begin
            state      <= ST_B0;
            load_ready <= 1'b1;
          end else begin
`ifdef WCS_CHECKSUM_EN
            state      <= ST_CHK;
            load_ready <= 1'b1;
`else
            state    <= ST_FIN;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end
        end
`ifdef WCS_CHECKSUM_EN
        ST_CHK: begin
          if (xfer) begin
            load_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            if (load_data == chk_acc) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              error <= 1'b1;
              state <= ST_IDLE;
            end
          end
        end
`endif
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wcs_loader.sv
module tb_wcs_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 22;
`ifdef WCS_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        load_data = 8'd0;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic              wcs_we;
  logic [ADDR_W-1:0] wcs_addr;
  logic [DATA_W-1:0] wcs_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  wcs_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .wcs_we     (wcs_we),
    .wcs_addr   (wcs_addr),
    .wcs_wdata  (wcs_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  int         done_seen = 0;
  logic [7:0] stim[$];
  int         exp_addr[$];
  int         exp_data[$];
  int         exp_done;
  int         exp_err;
  int         lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: parse the byte stream into the list of writes and the final outcome.
  task automatic model_load();
    int cnt, a, p, b0, b1, b2, x;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err  = 0;
    cnt = (stim[0] == 8'd0) ? 256 : int'(stim[0]);
    a   = int'(stim[1]);
    x   = int'(stim[0] ^ stim[1]);
    p   = 2;
    for (int w = 0; w < cnt; w++) begin
      if (p + 2 >= stim.size()) return;
      b0 = int'(stim[p]);
      b1 = int'(stim[p+1]);
      b2 = int'(stim[p+2]);
      p += 3;
      x = x ^ b0 ^ b1 ^ b2;
      if (b2 >= (1 << (DATA_W - 16))) begin
        exp_err = 1;
        return;
      end
      exp_addr.push_back(a);
      exp_data.push_back(b2 * 65536 + b1 * 256 + b0);
      a = (a + 1) % (1 << ADDR_W);
    end
`ifdef WCS_CHECKSUM_EN
    if (p < stim.size() && int'(stim[p]) == x) exp_done = 1;
    else exp_err = 1;
`else
    exp_done = 1;
`endif
  endtask

`ifdef WCS_CHECKSUM_EN
  function automatic logic [7:0] xor_all();
    logic [7:0] x;
    x = 8'd0;
    foreach (stim[k]) x ^= stim[k];
    return x;
  endfunction
`endif

  task automatic seal();
`ifdef WCS_CHECKSUM_EN
    stim.push_back(xor_all());
`endif
  endtask

  task automatic add_word(input int w);
    stim.push_back(w[7:0]);
    stim.push_back(w[15:8]);
    stim.push_back(w[23:16]);
  endtask

  // Every write the DUT makes must match the head of the expected list.
  always @(negedge clock) begin
    int ea, ed;
    if (wcs_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=0x%0h data=0x%0h expected=no write", wcs_addr, wcs_wdata);
      end else begin
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        chk("wr_addr", 32'(wcs_addr), ea);
        chk("wr_data", 32'(wcs_wdata), ed);
      end
    end
    if (done === 1'b1) done_seen++;
  end

  task automatic run_load(input string tag, input bit gap, input bit poke_start,
                          input int abort_at, output int cyc);
    int i;
    i = 0;
    cyc = 1;
    done_seen = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_hold_rise"}, 32'(cpu_hold), 1);
    chk({tag, "_err_clear"}, 32'(error), 0);
    while (cpu_hold === 1'b1 && cyc < 3000) begin
      if (abort_at >= 0 && i == abort_at) begin
        exp_addr.delete();
        exp_data.delete();
        load_data  = stim[i];
        load_valid = 1'b1;
        reset      = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        load_valid = 1'b0;
        return;
      end
      start = poke_start && (cyc == 6);
      if (i < stim.size() && !(gap && (cyc % 2 == 0))) begin
        load_valid = 1'b1;
        load_data  = stim[i];
      end else begin
        load_valid = 1'b0;
      end
      if (load_valid && load_ready === 1'b1) i++;
      @(negedge clock);
      cyc++;
    end
    load_valid = 1'b0;
    start      = 1'b0;
    if (cyc >= 3000) chk({tag, "_timeout_hold"}, 32'(cpu_hold), 0);
    repeat (2) @(negedge clock);
    chk({tag, "_done_pulses"}, done_seen, exp_done);
    chk({tag, "_error"}, 32'(error), exp_err);
    chk({tag, "_ready_low"}, 32'(load_ready), 0);
    chk({tag, "_writes_left"}, exp_addr.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clock);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_we", 32'(wcs_we), 0);
    chk("rst_addr", 32'(wcs_addr), 0);
    chk("rst_wdata", 32'(wcs_wdata), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    reset = 1'b0;

    // Two words at 0x10, back-to-back bytes: minimum latency.
    stim = '{8'd2, 8'h10};
    add_word('h3FFFFF);
    add_word('h000001);
    seal();
    model_load();
    chk("pin_t1_a0", exp_addr[0], 'h10);
    chk("pin_t1_d0", exp_data[0], 'h3FFFFF);
    chk("pin_t1_a1", exp_addr[1], 'h11);
    chk("pin_t1_d1", exp_data[1], 'h000001);
    run_load("t1", 1'b0, 1'b0, -1, lat);
    chk("t1_latency", lat, 2 + 4 * 2 + CHK_EXTRA + 1);
    chk("t1_hold_addr", 32'(wcs_addr), 'h11);
    chk("t1_hold_data", 32'(wcs_wdata), 'h000001);

    // Address wrap 0xFF -> 0x00.
    stim = '{8'd2, 8'hFF};
    add_word('h0ABCDE);
    add_word('h155555);
    seal();
    model_load();
    chk("pin_t2_a0", exp_addr[0], 'hFF);
    chk("pin_t2_a1", exp_addr[1], 'h00);
    run_load("t2", 1'b0, 1'b0, -1, lat);

    // Second word has a pad bit set: first word written, then error.
    stim = '{8'd2, 8'h20};
    add_word('h123456);
    stim.push_back(8'h00);
    stim.push_back(8'h00);
    stim.push_back(8'h40);
    model_load();
    chk("pin_t3_nwr", exp_addr.size(), 1);
    chk("pin_t3_err", exp_err, 1);
    run_load("t3", 1'b0, 1'b0, -1, lat);

    // Three words with valid toggling, plus a stray start mid-load.
    stim = '{8'd3, 8'h40};
    add_word('h2A5A5A);
    add_word('h00FF00);
    add_word('h13C3C3);
    seal();
    model_load();
    run_load("t4", 1'b1, 1'b1, -1, lat);

`ifdef WCS_CHECKSUM_EN
    // Checksum off by one: words written, error, no done.
    stim = '{8'd2, 8'h60};
    add_word('h111111);
    add_word('h222222);
    stim.push_back(xor_all() ^ 8'h01);
    model_load();
    chk("pin_t5_err", exp_err, 1);
    chk("pin_t5_nwr", exp_addr.size(), 2);
    run_load("t5", 1'b0, 1'b0, -1, lat);
`endif

    // Reset while the last byte of the first word is being transferred.
    stim = '{8'd1, 8'h30, 8'hAA, 8'hBB, 8'h0C};
    seal();
    model_load();
    run_load("t6", 1'b0, 1'b0, 4, lat);
    chk("t6_ready", 32'(load_ready), 0);
    chk("t6_we", 32'(wcs_we), 0);
    chk("t6_addr", 32'(wcs_addr), 0);
    chk("t6_wdata", 32'(wcs_wdata), 0);
    chk("t6_hold", 32'(cpu_hold), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_error", 32'(error), 0);

    // Start and reset together: reset wins.
    @(negedge clock);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    chk("t7_hold", 32'(cpu_hold), 0);
    chk("t7_ready", 32'(load_ready), 0);
    @(negedge clock);
    chk("t7_hold_later", 32'(cpu_hold), 0);

    // Fresh load after the abort.
    stim = '{8'd1, 8'h05};
    add_word('h2A0B0C);
    seal();
    model_load();
    chk("pin_t8_d0", exp_data[0], 'h2A0B0C);
    run_load("t8", 1'b0, 1'b0, -1, lat);

    // COUNT=0 means 256 words, wrapping through the whole store.
    stim = '{8'd0, 8'h80};
    for (int w = 0; w < 256; w++) add_word((w * 4099 + 7) & 'h3FFFFF);
    seal();
    model_load();
    chk("pin_t9_nwr", exp_addr.size(), 256);
    chk("pin_t9_last", exp_addr[255], 'h7F);
    run_load("t9", 1'b0, 1'b0, -1, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
